// File: rtl/dict_id_unpacker_pkg.sv
// Shared types and helpers for the dictionary-id unpacker: FSM state, bit-width type
// and the byte count of a low-contiguous keep mask.
package dict_id_unpacker_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StEmpty,
        StDrain
    } unpack_state_e;

    typedef logic [5:0] bit_width_t;

    localparam int unsigned MaxKeepBytes = 128;
    localparam int unsigned KeepCntW     = 8;

    function automatic logic [KeepCntW-1:0] keep_popcount(input logic [MaxKeepBytes-1:0] keep);
        logic [KeepCntW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MaxKeepBytes; i++) begin
            cnt = cnt + KeepCntW'(keep[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/dict_id_unpacker_gearbox.sv
// bit_gearbox: LSB-first bit buffer. Extraction (shift) uses the old contents, then the
// new beat is appended at the post-shift fill level.
module bit_gearbox #(
    parameter int unsigned BUF_BITS = 768,
    parameter int unsigned IN_BITS  = 512,
    parameter int unsigned WIN_BITS = 256,
    parameter int unsigned FILL_W   = $clog2(BUF_BITS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                append_en,
    input  logic [IN_BITS-1:0]  append_data,
    input  logic [FILL_W-1:0]   append_bits,
    input  logic                shift_en,
    input  logic [FILL_W-1:0]   shift_bits,
    output logic [WIN_BITS-1:0] window,
    output logic [FILL_W-1:0]   fill
);

    logic [BUF_BITS-1:0] bits_q, bits_d, shifted, incoming;
    logic [FILL_W-1:0]   fill_q, fill_d, fill_s;
    logic [IN_BITS-1:0]  mask;

    always_comb begin
        shifted = bits_q;
        fill_s  = fill_q;
        if (shift_en) begin
            shifted = bits_q >> shift_bits;
            fill_s  = fill_q - shift_bits;
        end
        // Bytes outside keep must not leak above the fill level.
        mask     = ~({IN_BITS{1'b1}} << append_bits);
        incoming = {{(BUF_BITS - IN_BITS){1'b0}}, append_data & mask} << fill_s;
        bits_d   = shifted;
        fill_d   = fill_s;
        if (clear) begin
            bits_d = '0;
            fill_d = '0;
        end else if (append_en) begin
            bits_d = shifted | incoming;
            fill_d = fill_s + append_bits;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bits_q <= '0;
            fill_q <= '0;
        end else begin
            bits_q <= bits_d;
            fill_q <= fill_d;
        end
    end

    assign window = bits_q[WIN_BITS-1:0];
    assign fill   = fill_q;

endmodule

// File: rtl/dict_id_unpacker.sv
// Unpacks LSB-first bit-packed dictionary ids from a byte stream into beats of
// NUM_ELEMENTS zero-extended ids with keep/last, one page per config handshake.
module dict_id_unpacker
    import dict_id_unpacker_pkg::*;
#(
    parameter int unsigned ID_BITS       = 16,
    parameter int unsigned DATABEAT_SIZE = 64,
    parameter int unsigned NUM_ELEMENTS  = DATABEAT_SIZE / 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  cfg_valid,
    output logic                                  cfg_ready,
    input  logic [5:0]                            cfg_bit_width,
    input  logic [31:0]                           cfg_count,
    input  logic [DATABEAT_SIZE*8-1:0]            in_data,
    input  logic [DATABEAT_SIZE-1:0]              in_keep,
    input  logic                                  in_last,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic [NUM_ELEMENTS-1:0][ID_BITS-1:0]  out_data,
    output logic [NUM_ELEMENTS-1:0]               out_keep,
    output logic                                  out_last,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  err
);

    localparam int unsigned IN_BITS  = DATABEAT_SIZE * 8;
    localparam int unsigned WIN_BITS = NUM_ELEMENTS * ID_BITS;
    localparam int unsigned BUF_BITS = IN_BITS + WIN_BITS;
    localparam int unsigned FILL_W   = $clog2(BUF_BITS + 1);
    localparam int unsigned CNT_W    = $clog2(NUM_ELEMENTS + 1);

    typedef logic [ID_BITS-1:0] id_t;

    unpack_state_e state_q, state_d;
    bit_width_t    bw_q, bw_d;
    logic [31:0]   remaining_q, remaining_d;
    logic          last_seen_q, last_seen_d;
    logic          err_q, err_d;
    logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [NUM_ELEMENTS-1:0]              out_keep_q, out_keep_d;
    logic [NUM_ELEMENTS-1:0][ID_BITS-1:0] out_data_q, out_data_d;

    logic                gb_clear, gb_append, gb_shift;
    logic [FILL_W-1:0]   gb_shift_bits, gb_append_bits, fill, need_bits, left_bits;
    logic [WIN_BITS-1:0] window, win_shift;
    id_t                 id_mask;
    id_t                 ids [NUM_ELEMENTS];
    logic [CNT_W-1:0]    n_req, n_x, avail_cnt;
    logic                full, out_free, in_fire;

    bit_gearbox #(
        .BUF_BITS (BUF_BITS),
        .IN_BITS  (IN_BITS),
        .WIN_BITS (WIN_BITS),
        .FILL_W   (FILL_W)
    ) u_gearbox (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (gb_clear),
        .append_en   (gb_append),
        .append_data (in_data),
        .append_bits (gb_append_bits),
        .shift_en    (gb_shift),
        .shift_bits  (gb_shift_bits),
        .window      (window),
        .fill        (fill)
    );

    assign gb_append_bits = FILL_W'({keep_popcount(MaxKeepBytes'(in_keep)), 3'b000});
    assign out_free       = !out_valid_q || out_ready;
    assign in_fire        = in_valid && in_ready;

    // Id slicing and availability of complete ids in the buffer.
    always_comb begin
        id_mask = ~({ID_BITS{1'b1}} << bw_q);
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            win_shift = window >> (i * bw_q);
            ids[i]    = win_shift[ID_BITS-1:0] & id_mask;
        end
        n_req     = (remaining_q >= 32'(NUM_ELEMENTS)) ? CNT_W'(NUM_ELEMENTS) : CNT_W'(remaining_q);
        need_bits = FILL_W'(n_req) * FILL_W'(bw_q);
        full      = (fill >= need_bits);
        avail_cnt = '0;
        for (int i = 1; i <= NUM_ELEMENTS; i++) begin
            if (FILL_W'(i) * FILL_W'(bw_q) <= fill) begin
                avail_cnt = avail_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        cfg_ready = rst_n && (state_q == StIdle) && !out_valid_q;
        in_ready  = 1'b0;
        unique case (state_q)
            StRun:           in_ready = (32'(fill) + IN_BITS <= BUF_BITS) && out_free
                                        && !last_seen_q;
            StEmpty, StDrain: in_ready = 1'b1;
            default:         in_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        bw_d          = bw_q;
        remaining_d   = remaining_q;
        last_seen_d   = last_seen_q;
        err_d         = err_q;
        out_valid_d   = out_valid_q && !out_ready;
        out_data_d    = out_data_q;
        out_keep_d    = out_keep_q;
        out_last_d    = out_last_q;
        gb_clear      = (state_q != StRun);
        gb_append     = 1'b0;
        gb_shift      = 1'b0;
        gb_shift_bits = '0;
        n_x           = '0;
        left_bits     = fill;
        unique case (state_q)
            StIdle: begin
                if (cfg_valid && cfg_ready) begin
                    err_d       = 1'b0;
                    bw_d        = cfg_bit_width;
                    remaining_d = cfg_count;
                    last_seen_d = 1'b0;
                    if (cfg_bit_width == '0 || 32'(cfg_bit_width) > ID_BITS) begin
                        err_d   = 1'b1;
                        state_d = StDrain;
                    end else if (cfg_count == '0) begin
                        state_d = StEmpty;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                gb_append = in_fire;
                if (in_fire && in_last) last_seen_d = 1'b1;
                // After in_last, a short buffer flushes whatever complete ids remain.
                if (out_free && (full || last_seen_q)) begin
                    n_x           = full ? n_req : avail_cnt;
                    gb_shift      = 1'b1;
                    gb_shift_bits = FILL_W'(n_x) * FILL_W'(bw_q);
                    left_bits     = fill - gb_shift_bits;
                    out_valid_d   = 1'b1;
                    out_last_d    = 1'b0;
                    for (int i = 0; i < NUM_ELEMENTS; i++) begin
                        out_keep_d[i] = (CNT_W'(i) < n_x);
                        out_data_d[i] = out_keep_d[i] ? ids[i] : '0;
                    end
                    remaining_d = remaining_q - 32'(n_x);
                    if (full && remaining_q == 32'(n_req)) begin
                        out_last_d = 1'b1;
                        gb_clear   = 1'b1;
                        state_d    = (last_seen_q || (in_fire && in_last)) ? StIdle : StDrain;
                    end else if (last_seen_q && left_bits < FILL_W'(bw_q)) begin
                        err_d      = 1'b1;
                        out_last_d = 1'b1;
                        gb_clear   = 1'b1;
                        state_d    = StIdle;
                    end
                end
            end
            StEmpty: begin
                if (in_fire && in_last) last_seen_d = 1'b1;
                if (out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = '0;
                    out_keep_d  = '0;
                    out_last_d  = 1'b1;
                    state_d     = (last_seen_q || (in_fire && in_last)) ? StIdle : StDrain;
                end
            end
            StDrain: begin
                if (in_fire && in_last) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            bw_q        <= '0;
            remaining_q <= '0;
            last_seen_q <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bw_q        <= bw_d;
            remaining_q <= remaining_d;
            last_seen_q <= last_seen_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dict_id_unpacker.sv
// Directed page scenarios with random payloads; expected ids come from a flat bit-array
// model of the packed stream.
module tb_dict_id_unpacker;

    localparam int IDB = 16;
    localparam int DBS = 64;
    localparam int NE  = 16;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     cfg_valid = 1'b0;
    logic                     cfg_ready;
    logic [5:0]               cfg_bit_width = '0;
    logic [31:0]              cfg_count = '0;
    logic [DBS*8-1:0]         in_data = '0;
    logic [DBS-1:0]           in_keep = '0;
    logic                     in_last = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [NE-1:0][IDB-1:0]   out_data;
    logic [NE-1:0]            out_keep;
    logic                     out_last;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic                     err;

    int total = 0;
    int bad   = 0;
    bit rand_ready = 1'b0;

    byte unsigned   pay [0:511];
    logic [255:0]   q_data [$];
    logic [15:0]    q_keep [$];
    logic           q_last [$];

    always #5 clk = ~clk;

    dict_id_unpacker #(
        .ID_BITS       (IDB),
        .DATABEAT_SIZE (DBS),
        .NUM_ELEMENTS  (NE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_bit_width (cfg_bit_width),
        .cfg_count     (cfg_count),
        .in_data       (in_data),
        .in_keep       (in_keep),
        .in_last       (in_last),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_keep      (out_keep),
        .out_last      (out_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .err           (err)
    );

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_keep.push_back(out_keep);
            q_last.push_back(out_last);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_id(input int bw, input int k);
        logic [15:0] v;
        int j;
        v = '0;
        for (int b = 0; b < bw; b++) begin
            j = k * bw + b;
            v[b] = pay[j / 8][j % 8];
        end
        return v;
    endfunction

    task automatic do_cfg(input int bw, input int cnt);
        int cyc;
        bit got;
        cfg_bit_width = 6'(bw);
        cfg_count     = 32'(cnt);
        cfg_valid     = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 3000) begin
            @(negedge clk);
            got = cfg_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        cfg_valid = 1'b0;
        check("cfg_accept", 256'(got), 256'(1));
        @(negedge clk);
        check("err_after_cfg", 256'(err), 256'(bw == 0 || bw > IDB));
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int t, input int nbytes, input bit lst);
        int cyc;
        int idx;
        bit got;
        for (int b = 0; b < DBS; b++) begin
            idx = t * DBS + b;
            in_data[b*8 +: 8] = (idx < nbytes) ? pay[idx] : 8'($urandom);
            in_keep[b]        = (idx < nbytes);
        end
        in_last  = lst;
        in_valid = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 3000) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("in_accept", 256'(got), 256'(1));
    endtask

    task automatic run_page(input string name, input int bw, input int cnt, input int nbytes,
                            input int nbeats, input bit rr);
        int avail, exp_beats, cyc;
        bit illegal, exp_err;
        logic [255:0] ed;
        logic [15:0]  ek;
        q_data.delete();
        q_keep.delete();
        q_last.delete();
        rand_ready = rr;
        do_cfg(bw, cnt);
        for (int t = 0; t < nbeats; t++) send_beat(t, nbytes, t == nbeats - 1);
        illegal = (bw == 0 || bw > IDB);
        if (illegal) begin
            avail = 0;
            exp_beats = 0;
        end else if (cnt == 0) begin
            avail = 0;
            exp_beats = 1;
        end else begin
            avail = (nbytes * 8) / bw;
            if (avail > cnt) avail = cnt;
            exp_beats = (avail + NE - 1) / NE;
        end
        exp_err = illegal || (cnt != 0 && avail < cnt);
        cyc = 0;
        while (q_data.size() < exp_beats && cyc < 5000) begin
            @(posedge clk);
            cyc++;
        end
        repeat (8) @(posedge clk);
        @(negedge clk);
        check($sformatf("%s_beats", name), 256'(q_data.size()), 256'(exp_beats));
        for (int bi = 0; bi < exp_beats && bi < q_data.size(); bi++) begin
            ed = '0;
            ek = '0;
            for (int s = 0; s < NE; s++) begin
                if (bi * NE + s < avail) begin
                    ed[s*16 +: 16] = ref_id(bw, bi * NE + s);
                    ek[s] = 1'b1;
                end
            end
            check($sformatf("%s_b%0d_data", name, bi), q_data[bi], ed);
            check($sformatf("%s_b%0d_keep", name, bi), 256'(q_keep[bi]), 256'(ek));
            check($sformatf("%s_b%0d_last", name, bi), 256'(q_last[bi]),
                  256'(bi == exp_beats - 1));
        end
        check($sformatf("%s_err", name), 256'(err), 256'(exp_err));
        check($sformatf("%s_idle", name), 256'(cfg_ready), 256'(1));
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [255:0] seq_ids;
        for (int i = 0; i < 512; i++) pay[i] = 8'($urandom);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cfg_ready", 256'(cfg_ready), 256'(0));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_out_keep", 256'(out_keep), 256'(0));
        check("rst_out_last", 256'(out_last), 256'(0));
        check("rst_in_ready", 256'(in_ready), 256'(0));
        check("rst_err", 256'(err), 256'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_cfg_ready", 256'(cfg_ready), 256'(1));
        @(posedge clk);
        #1;

        // bw=4: nibbles 0..F in the first eight bytes
        for (int i = 0; i < 8; i++) pay[i] = 8'(((2 * i + 1) << 4) | (2 * i));
        run_page("bw4", 4, 16, 64, 1, 1'b0);
        seq_ids = '0;
        for (int i = 0; i < NE; i++) seq_ids[i*16 +: 16] = 16'(i);
        check("bw4_ids_const", q_data[0], seq_ids);

        for (int i = 0; i < 512; i++) pay[i] = 8'($urandom);
        run_page("bw13", 13, 100, 212, 4, 1'b1);
        check("bw13_last_keep", 256'(q_keep[6]), 256'(16'h000F));

        for (int i = 0; i < 512; i++) pay[i] = 8'($urandom);
        run_page("bw16", 16, 20, 192, 3, 1'b0);

        run_page("empty", 5, 0, 64, 1, 1'b0);

        for (int i = 0; i < 512; i++) pay[i] = 8'($urandom);
        run_page("short", 8, 80, 64, 1, 1'b0);

        run_page("illegal", 17, 10, 64, 1, 1'b0);

        // Mid-page reset after two of five beats
        for (int i = 0; i < 512; i++) pay[i] = 8'($urandom);
        do_cfg(7, 300);
        send_beat(0, 320, 1'b0);
        send_beat(1, 320, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_cfg_ready", 256'(cfg_ready), 256'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_out_valid", 256'(out_valid), 256'(0));
        check("midrst_err", 256'(err), 256'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_cfg_ready", 256'(cfg_ready), 256'(1));
        @(posedge clk);
        #1;

        for (int i = 0; i < 512; i++) pay[i] = 8'($urandom);
        run_page("bw1", 1, 512, 64, 1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
